// File: rtl/text_update_sched_if.sv
// Bundle between the field updaters / VGA counter and the font character store.
// The requester side (master) drives requests, field bytes and V_ON; the scheduler (slave) drives the write port.
interface text_update_sched_if;
  logic        V_ON;
  logic [2:0]  req;
  logic [23:0] dat_fecha;
  logic [23:0] dat_hora;
  logic [23:0] dat_crono;
  logic [2:0]  ack;
  logic        busy;
  logic [7:0]  DIR_DATO;
  logic [3:0]  POSICION;
  logic        RD;

  modport master (
    output V_ON, req, dat_fecha, dat_hora, dat_crono,
    input  ack, busy, DIR_DATO, POSICION, RD
  );

  modport slave (
    input  V_ON, req, dat_fecha, dat_hora, dat_crono,
    output ack, busy, DIR_DATO, POSICION, RD
  );
endinterface

// File: rtl/text_update_sched.sv
// Round-robin scheduler that copies 3-byte date/time/chrono fields into the text
// character store, issuing the byte writes only during vertical blanking.
//
// state   | meaning
// S_IDLE  | waiting for a request; the cycle right after a burst only clears busy
// S_WRITE | field latched; one byte written per edge while V_ON is low
module text_update_sched #(
  parameter logic [3:0] BASE_FECHA = 4'd0,
  parameter logic [3:0] BASE_HORA  = 4'd3,
  parameter logic [3:0] BASE_CRONO = 4'd6
) (
  input  logic              reloj,
  input  logic              resetM,
  text_update_sched_if.slave bus
);

  typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

  state_t      r_state;
  logic [1:0]  r_rr;
  logic [1:0]  r_gnt;
  logic [1:0]  r_idx;
  logic [23:0] r_buf;
  logic [3:0]  r_base;
  logic [2:0]  r_ack;
  logic        r_busy;
  logic        r_rd;
  logic [7:0]  r_dato;
  logic [3:0]  r_pos;

  logic [2:0]  w_rot;
  logic [1:0]  w_off;
  logic [2:0]  w_sum;
  logic [1:0]  w_gnt;
  logic        w_gnt_vld;
  logic [23:0] w_dat_sel;
  logic [3:0]  w_base_sel;
  logic [7:0]  w_byte;
  logic [1:0]  w_rr_next;

  // Rotate req so bit 0 is the requester currently holding highest priority.
  always_comb begin
    w_rot = bus.req;
    case (r_rr)
      2'd1:    w_rot = {bus.req[0], bus.req[2:1]};
      2'd2:    w_rot = {bus.req[1:0], bus.req[2]};
      default: w_rot = bus.req;
    endcase
  end

  always_comb begin
    w_off = 2'd2;
    if (w_rot[0])
      w_off = 2'd0;
    else if (w_rot[1])
      w_off = 2'd1;
  end

  assign w_gnt_vld = |bus.req;
  assign w_sum     = {1'b0, r_rr} + {1'b0, w_off};

  always_comb begin
    w_gnt = w_sum[1:0];
    if (w_sum >= 3'd3)
      w_gnt = 2'(w_sum - 3'd3);
  end

  always_comb begin
    w_dat_sel  = bus.dat_fecha;
    w_base_sel = BASE_FECHA;
    case (w_gnt)
      2'd1: begin
        w_dat_sel  = bus.dat_hora;
        w_base_sel = BASE_HORA;
      end
      2'd2: begin
        w_dat_sel  = bus.dat_crono;
        w_base_sel = BASE_CRONO;
      end
      default: begin
        w_dat_sel  = bus.dat_fecha;
        w_base_sel = BASE_FECHA;
      end
    endcase
  end

  always_comb begin
    w_byte = r_buf[7:0];
    case (r_idx)
      2'd0:    w_byte = r_buf[23:16];
      2'd1:    w_byte = r_buf[15:8];
      default: w_byte = r_buf[7:0];
    endcase
  end

  assign w_rr_next = (r_gnt == 2'd2) ? 2'd0 : r_gnt + 2'd1;

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      r_state <= S_IDLE;
      r_rr    <= 2'd0;
      r_gnt   <= 2'd0;
      r_idx   <= 2'd0;
      r_buf   <= 24'd0;
      r_base  <= 4'd0;
      r_ack   <= 3'd0;
      r_busy  <= 1'b0;
      r_rd    <= 1'b0;
      r_dato  <= 8'd0;
      r_pos   <= 4'd0;
    end else begin
      r_ack <= 3'd0;
      r_rd  <= 1'b0;
      if (r_state == S_IDLE) begin
        // busy still high here means the burst just ended; spend this edge dropping it.
        if (r_busy) begin
          r_busy <= 1'b0;
        end else if (w_gnt_vld) begin
          r_ack   <= 3'b001 << w_gnt;
          r_busy  <= 1'b1;
          r_buf   <= w_dat_sel;
          r_base  <= w_base_sel;
          r_gnt   <= w_gnt;
          r_idx   <= 2'd0;
          r_state <= S_WRITE;
        end
      end else begin
        if (!bus.V_ON) begin
          r_rd   <= 1'b1;
          r_dato <= w_byte;
          r_pos  <= r_base + {2'b00, r_idx};
          if (r_idx == 2'd2) begin
            r_idx   <= 2'd0;
            r_rr    <= w_rr_next;
            r_state <= S_IDLE;
          end else begin
            r_idx <= r_idx + 2'd1;
          end
        end
      end
    end
  end

  assign bus.ack      = r_ack;
  assign bus.busy     = r_busy;
  assign bus.RD       = r_rd;
  assign bus.DIR_DATO = r_dato;
  assign bus.POSICION = r_pos;

endmodule
